// File: rtl/seg595_pkg.sv
// Shared constants for the 74HC595 seven-segment scan controller:
// the hex glyph table, frame geometry and scan FSM states.
package seg595_pkg;

    localparam int unsigned FRAME_W = 14;
    localparam int unsigned PHASES  = 4;

    // Active-low common-anode glyphs, dp bit (bit 7) off; entry n is glyph for hex n
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg595_scan_ctrl_seg_hex_decode.sv
// Combinational hex digit to active-low gfedcba segment decoder.
module seg_hex_decode
    import seg595_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = HEX_SEG[hex][6:0];
    end

endmodule

// File: rtl/seg595_scan_ctrl.sv
// Digit scan scheduler: every slot it shifts one {seg,sel} frame MSB-first
// into the 595 chain, latches it, and drives the active-low output enable.
module seg595_scan_ctrl
    import seg595_pkg::*;
#(
    parameter int unsigned SCAN_CNT = 50_000,
    parameter int unsigned DIGITS   = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dots,
    input  logic [DIGITS-1:0]     digit_en,
    output logic                  stcp,
    output logic                  shcp,
    output logic                  ds,
    output logic                  oe,
    output logic                  busy
);

    localparam int unsigned     TW         = $clog2(SCAN_CNT);
    localparam logic [TW-1:0]   TIMER_MAX  = TW'(SCAN_CNT - 1);
    localparam logic [2:0]      IDX_MAX    = 3'(DIGITS - 1);
    localparam logic [3:0]      LAST_BIT   = 4'(FRAME_W - 1);
    localparam logic [1:0]      PHASE_LAST = 2'(PHASES - 1);

    logic [TW-1:0]        timer;
    logic [2:0]           idx;

    logic [3:0]           cur_hex;
    logic                 cur_dot;
    logic                 cur_en;
    logic [6:0]           dec;
    logic [7:0]           cur_seg;
    logic [DIGITS-1:0]    cur_sel;
    logic [FRAME_W-1:0]   frame_w;

    scan_state_t          state;
    logic [1:0]           phase;
    logic [3:0]           bit_cnt;
    logic [FRAME_W-2:0]   shreg;
    logic                 shown;

    // Slot timer and digit index run regardless of en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
            idx   <= '0;
        end else if (timer == TIMER_MAX) begin
            timer <= '0;
            idx   <= (idx == IDX_MAX) ? '0 : idx + 3'd1;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    seg_hex_decode u_dec (
        .hex   (cur_hex),
        .seg_n (dec)
    );

    always_comb begin
        cur_hex = '0;
        cur_dot = 1'b0;
        cur_en  = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == 3'(i)) begin
                cur_hex = digits[4*i +: 4];
                cur_dot = dots[i];
                cur_en  = digit_en[i];
            end
        end
        cur_sel = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
        cur_seg = cur_en ? {~cur_dot, dec} : 8'hFF;
        frame_w = {cur_seg, cur_sel};
    end

    // ds carries W[13] straight from the snapshot, so shreg only holds W[12:0].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            shown   <= 1'b0;
            stcp    <= 1'b0;
            shcp    <= 1'b0;
            ds      <= 1'b0;
            oe      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            if (shown) begin
                oe <= ~en;
            end
            case (state)
                IDLE: begin
                    if (timer == '0 && en) begin
                        state   <= SHIFT;
                        phase   <= '0;
                        bit_cnt <= '0;
                        shreg   <= frame_w[FRAME_W-2:0];
                        ds      <= frame_w[FRAME_W-1];
                        shcp    <= 1'b0;
                        stcp    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (phase == PHASE_LAST) begin
                        phase <= '0;
                        shcp  <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= LATCH;
                            ds    <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            ds      <= shreg[FRAME_W-2];
                            shreg   <= {shreg[FRAME_W-3:0], 1'b0};
                        end
                    end else begin
                        // shcp is high in the second half of each bit period
                        phase <= phase + 2'd1;
                        shcp  <= (phase != '0);
                    end
                end
                LATCH: begin
                    if (phase == PHASE_LAST) begin
                        state <= IDLE;
                        phase <= '0;
                        stcp  <= 1'b0;
                        busy  <= 1'b0;
                        shown <= 1'b1;
                        oe    <= ~en;
                    end else begin
                        phase <= phase + 2'd1;
                        stcp  <= (phase != '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
